// File: rtl/blackbox_check_monitor_if.sv
// Report channel of the black-box check monitor.
// The monitor drives the report word; the consumer drives rpt_ready.
interface blackbox_check_monitor_if #(
    parameter int NUM_CHECKS = 8,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = 3
);
    logic                  rpt_valid;
    logic                  rpt_ready;
    logic                  rpt_pass;
    logic                  rpt_aborted;
    logic [CNT_W-1:0]      rpt_fail_count;
    logic [IDX_W-1:0]      rpt_first_fail;
    logic [CNT_W-1:0]      rpt_first_cycle;
    logic [NUM_CHECKS-1:0] rpt_fail_mask;
    logic [NUM_CHECKS-1:0] rpt_checked_mask;

    modport master (
        output rpt_valid,
        output rpt_pass,
        output rpt_aborted,
        output rpt_fail_count,
        output rpt_first_fail,
        output rpt_first_cycle,
        output rpt_fail_mask,
        output rpt_checked_mask,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_pass,
        input  rpt_aborted,
        input  rpt_fail_count,
        input  rpt_first_fail,
        input  rpt_first_cycle,
        input  rpt_fail_mask,
        input  rpt_checked_mask,
        output rpt_ready
    );
endinterface

// File: rtl/blackbox_check_monitor.sv
// Collects per-check pass/valid strobes over a run window
// and emits a single registered verdict word.
module blackbox_check_monitor #(
    parameter int NUM_CHECKS = 8,
    parameter int RUN_CYCLES = 4,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_CHECKS-1:0] chk_valid,
    input  logic [NUM_CHECKS-1:0] chk_pass,
    output logic                  busy,
    blackbox_check_monitor_if.master rpt
);
    localparam int PC_W  = $clog2(NUM_CHECKS + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]      cyc;
    logic [CNT_W-1:0]      fail_count;
    logic [IDX_W-1:0]      first_fail;
    logic [CNT_W-1:0]      first_cycle;
    logic [NUM_CHECKS-1:0] fail_mask;
    logic [NUM_CHECKS-1:0] checked_mask;
    logic                  aborted;
    logic                  pass_q;
    logic                  have_first;

    logic [NUM_CHECKS-1:0] fail;
    logic [PC_W-1:0]       pc;
    logic [IDX_W-1:0]      low_idx;
    logic [SUM_W-1:0]      sum;
    logic [CNT_W-1:0]      count_nx;
    logic [NUM_CHECKS-1:0] chk_nx;
    logic                  last;

    always_comb begin
        fail    = chk_valid & ~chk_pass;
        pc      = '0;
        low_idx = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (fail[i]) low_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_CHECKS; i++) begin
            pc = pc + PC_W'(fail[i]);
        end
        sum      = SUM_W'(fail_count) + SUM_W'(pc);
        count_nx = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX
                                            : sum[CNT_W-1:0];
        chk_nx   = checked_mask | chk_valid;
        last     = (cyc == CNT_W'(RUN_CYCLES - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (abort || last) state_nx = REPORT;
            REPORT:  if (rpt.rpt_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        rpt.rpt_valid = (state == REPORT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc          <= '0;
            fail_count   <= '0;
            first_fail   <= '0;
            first_cycle  <= '0;
            fail_mask    <= '0;
            checked_mask <= '0;
            aborted      <= 1'b0;
            pass_q       <= 1'b0;
            have_first   <= 1'b0;
        end else if (state == IDLE && start) begin
            cyc          <= '0;
            fail_count   <= '0;
            first_fail   <= '0;
            first_cycle  <= '0;
            fail_mask    <= '0;
            checked_mask <= '0;
            aborted      <= 1'b0;
            pass_q       <= 1'b0;
            have_first   <= 1'b0;
        end else if (state == RUN) begin
            // an aborted cycle contributes nothing to the report
            if (abort) begin
                aborted <= 1'b1;
                pass_q  <= 1'b0;
            end else begin
                cyc          <= cyc + 1'b1;
                fail_count   <= count_nx;
                fail_mask    <= fail_mask | fail;
                checked_mask <= chk_nx;
                if (!have_first && fail != '0) begin
                    have_first  <= 1'b1;
                    first_fail  <= low_idx;
                    first_cycle <= cyc;
                end
                if (last) begin
                    pass_q <= (count_nx == '0) && (&chk_nx);
                end
            end
        end
    end

    assign rpt.rpt_pass         = pass_q;
    assign rpt.rpt_aborted      = aborted;
    assign rpt.rpt_fail_count   = fail_count;
    assign rpt.rpt_first_fail   = first_fail;
    assign rpt.rpt_first_cycle  = first_cycle;
    assign rpt.rpt_fail_mask    = fail_mask;
    assign rpt.rpt_checked_mask = checked_mask;
endmodule

// File: tb/tb_blackbox_check_monitor.sv
// Directed bench for blackbox_check_monitor: two widths of
// failure counter run in lockstep against a run-level model.
module tb_blackbox_check_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] cv = '0;
    logic [7:0] cp = '0;
    logic       busy8;
    logic       busy2;

    always #5 clk = ~clk;

    blackbox_check_monitor_if #(
        .NUM_CHECKS(8), .CNT_W(8), .IDX_W(3)
    ) b8 ();
    blackbox_check_monitor_if #(
        .NUM_CHECKS(8), .CNT_W(2), .IDX_W(3)
    ) b2 ();

    assign b8.rpt_ready = rdy;
    assign b2.rpt_ready = rdy;

    blackbox_check_monitor #(
        .NUM_CHECKS(8), .RUN_CYCLES(4),
        .CNT_W(8), .IDX_W(3)
    ) dut8 (
        .clock(clk), .reset(rst_n),
        .start(start), .abort(abort),
        .chk_valid(cv), .chk_pass(cp),
        .busy(busy8), .rpt(b8)
    );

    blackbox_check_monitor #(
        .NUM_CHECKS(8), .RUN_CYCLES(4),
        .CNT_W(2), .IDX_W(3)
    ) dut2 (
        .clock(clk), .reset(rst_n),
        .start(start), .abort(abort),
        .chk_valid(cv), .chk_pass(cp),
        .busy(busy2), .rpt(b2)
    );

    typedef struct {
        bit         pass;
        bit         ab;
        int         cnt;
        int         first;
        int         fcyc;
        logic [7:0] fm;
        logic [7:0] cm;
    } rep_t;

    rep_t       e;
    bit         mdl_busy = 1'b0;
    bit         mdl_rv = 1'b0;
    bit         fields_on = 1'b1;
    int         tests = 0;
    int         failed = 0;
    int         cur = 0;
    logic [7:0] sv [4];
    logic [7:0] sp [4];

    function automatic rep_t zero_rep();
        rep_t r;
        r.pass = 0; r.ab = 0; r.cnt = 0;
        r.first = 0; r.fcyc = 0;
        r.fm = '0; r.cm = '0;
        return r;
    endfunction

    // report implied by the first n accepted samples of the run
    function automatic rep_t expect_of(input int n, input bit ab);
        rep_t r;
        logic [7:0] f;
        bit found;
        r = zero_rep();
        found = 0;
        for (int c = 0; c < n; c++) begin
            f = sv[c] & ~sp[c];
            r.cm |= sv[c];
            r.fm |= f;
            for (int b = 0; b < 8; b++) r.cnt += int'(f[b]);
            if (!found && f != 0) begin
                found = 1;
                r.fcyc = c;
                for (int b = 7; b >= 0; b--)
                    if (f[b]) r.first = b;
            end
        end
        r.ab = ab;
        r.pass = (r.cnt == 0) && (r.cm == 8'hFF) && !ab;
        return r;
    endfunction

    function automatic int sat(input int x, input int cap);
        return (x > cap) ? cap : x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] ex);
        tests++;
        if (act !== ex) begin
            failed++;
            $display("FAIL t%0d %s: got %0h expected %0h",
                     cur, nm, act, ex);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 32'(busy8), 32'(mdl_busy));
        chk("busy_w2", 32'(busy2), 32'(mdl_busy));
        chk("valid", 32'(b8.rpt_valid), 32'(mdl_rv));
        chk("valid_w2", 32'(b2.rpt_valid), 32'(mdl_rv));
        if (fields_on) begin
            chk("pass", 32'(b8.rpt_pass), 32'(e.pass));
            chk("pass_w2", 32'(b2.rpt_pass), 32'(e.pass));
            chk("aborted", 32'(b8.rpt_aborted), 32'(e.ab));
            chk("aborted_w2", 32'(b2.rpt_aborted), 32'(e.ab));
            chk("count", 32'(b8.rpt_fail_count), sat(e.cnt, 255));
            chk("count_w2", 32'(b2.rpt_fail_count), sat(e.cnt, 3));
            chk("first", 32'(b8.rpt_first_fail), e.first);
            chk("first_w2", 32'(b2.rpt_first_fail), e.first);
            chk("fcyc", 32'(b8.rpt_first_cycle), e.fcyc);
            chk("fcyc_w2", 32'(b2.rpt_first_cycle), e.fcyc);
            chk("fmask", 32'(b8.rpt_fail_mask), 32'(e.fm));
            chk("fmask_w2", 32'(b2.rpt_fail_mask), 32'(e.fm));
            chk("cmask", 32'(b8.rpt_checked_mask), 32'(e.cm));
            chk("cmask_w2", 32'(b2.rpt_checked_mask), 32'(e.cm));
        end
    end

    task automatic run(input int abort_at, input int wait_n,
                       input bit pulse, input bit hs_start);
        int n;
        bit ab;
        @(negedge clk);
        start = 1; rdy = 0;
        @(posedge clk);
        mdl_busy = 1; fields_on = 0;
        n = 0; ab = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 0; cv = sv[k]; cp = sp[k];
            abort = (k == abort_at);
            @(posedge clk);
            if (k == abort_at) begin
                ab = 1;
                break;
            end
            n++;
        end
        e = expect_of(n, ab);
        mdl_rv = 1; fields_on = 1;
        @(negedge clk);
        cv = '0; cp = '0; abort = 0;
        for (int w = 0; w < wait_n; w++) begin
            start = pulse && (w == 2);
            abort = pulse && (w == 4);
            cv = pulse ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        start = 0; abort = 0; cv = '0;
        rdy = 1; start = hs_start;
        @(posedge clk);
        mdl_rv = 0; mdl_busy = 0;
        @(negedge clk);
        rdy = 0; start = 0;
    endtask

    task automatic fill(input logic [7:0] v, input logic [7:0] p);
        for (int k = 0; k < 4; k++) begin
            sv[k] = v; sp[k] = p;
        end
    endtask

    initial begin
        e = zero_rep();
        fill(8'hFF, 8'hFF);
        cur = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        repeat (2) @(negedge clk);

        cur = 1;
        fill(8'hFF, 8'hFF);
        run(-1, 0, 0, 0);
        chk("t1 pass", 32'(b8.rpt_pass), 1);
        chk("t1 count", 32'(b8.rpt_fail_count), 0);
        chk("t1 cmask", 32'(b8.rpt_checked_mask), 32'hFF);

        cur = 2;
        fill(8'hFF, 8'hFF);
        sp[2] = 8'hF5;
        run(-1, 2, 0, 1);
        chk("t2 count", 32'(b8.rpt_fail_count), 2);
        chk("t2 first", 32'(b8.rpt_first_fail), 1);
        chk("t2 fcyc", 32'(b8.rpt_first_cycle), 2);
        chk("t2 fmask", 32'(b8.rpt_fail_mask), 32'h0A);
        chk("t2 pass", 32'(b8.rpt_pass), 0);

        cur = 3;
        fill(8'h7F, 8'hFF);
        run(-1, 1, 0, 0);
        chk("t3 cmask", 32'(b8.rpt_checked_mask), 32'h7F);
        chk("t3 pass", 32'(b8.rpt_pass), 0);
        chk("t3 count", 32'(b8.rpt_fail_count), 0);

        cur = 4;
        fill(8'hFF, 8'h00);
        run(-1, 0, 0, 0);
        chk("t4 count_w2", 32'(b2.rpt_fail_count), 3);
        chk("t4 count", 32'(b8.rpt_fail_count), 32);
        chk("t4 first", 32'(b2.rpt_first_fail), 0);
        chk("t4 fcyc", 32'(b2.rpt_first_cycle), 0);

        cur = 5;
        fill(8'hFF, 8'hFF);
        sp[1] = 8'h00;
        run(1, 3, 0, 0);
        chk("t5 aborted", 32'(b8.rpt_aborted), 1);
        chk("t5 count", 32'(b8.rpt_fail_count), 0);
        chk("t5 pass", 32'(b8.rpt_pass), 0);
        chk("t5 cmask", 32'(b8.rpt_checked_mask), 32'hFF);

        cur = 6;
        fill(8'hFF, 8'hFF);
        sv[0] = 8'hF0; sp[0] = 8'h00;
        sp[2] = 8'hFE;
        run(-1, 1, 0, 0);
        chk("t6 count", 32'(b8.rpt_fail_count), 5);
        chk("t6 first", 32'(b8.rpt_first_fail), 4);
        chk("t6 fmask", 32'(b8.rpt_fail_mask), 32'hF1);

        cur = 7;
        fill(8'hFF, 8'hFF);
        sp[1] = 8'hEF; sp[3] = 8'hFE;
        run(-1, 10, 1, 0);
        chk("t7 first", 32'(b8.rpt_first_fail), 4);
        chk("t7 fcyc", 32'(b8.rpt_first_cycle), 1);
        chk("t7 fmask", 32'(b8.rpt_fail_mask), 32'h11);

        cur = 8;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        mdl_busy = 1; fields_on = 0;
        @(negedge clk);
        start = 0; cv = 8'hFF; cp = 8'h00;
        repeat (2) @(posedge clk);
        #2 rst_n = 0;
        mdl_busy = 0; mdl_rv = 0;
        e = zero_rep(); fields_on = 1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        repeat (6) @(negedge clk);
        cv = '0;
        chk("t8 count", 32'(b8.rpt_fail_count), 0);
        chk("t8 valid", 32'(b8.rpt_valid), 0);

        cur = 9;
        fill(8'hFF, 8'hFF);
        run(-1, 0, 0, 0);
        chk("t9 pass", 32'(b8.rpt_pass), 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
